// File: rtl/alu_result_history_pkg.sv
// Shared entry layout and FSM encodings for the ALU result history block.
package alu_result_history_pkg;
  localparam int ENTRY_W = 23;
  localparam int RES_LSB = 0;
  localparam int RES_W   = 16;
  localparam int REM_LSB = 16;
  localparam int REM_W   = 4;
  localparam int DIV_BIT = 20;
  localparam int OP_LSB  = 21;
  localparam int OP_W    = 2;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_LIVE   = 2'd1,
    ST_BROWSE = 2'd2
  } state_t;
endpackage

// File: rtl/alu_result_history_regfile.sv
// DEPTH x W register file: synchronous write, asynchronous read.
module history_regfile #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int W     = 23
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/alu_result_history.sv
// Circular history of committed ALU results with prev/next browsing for the display path.
module alu_result_history
  import alu_result_history_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          commit,
  input  logic [15:0]   result,
  input  logic [3:0]    rem_disp,
  input  logic          divide_flag,
  input  logic [1:0]    alu_op,
  input  logic          prev_btn,
  input  logic          next_btn,
  input  logic          clear,
  output logic [15:0]   view_result,
  output logic [3:0]    view_rem,
  output logic [1:0]    view_op,
  output logic          view_div,
  output logic [AW-1:0] view_age,
  output logic [AW:0]   count,
  output logic          live,
  output logic          empty
);
  state_t               state;
  logic [AW-1:0]        wr_ptr, nxt_age, raddr;
  logic [ENTRY_W-1:0]   wdata, rdata;

  assign wdata = {alu_op, divide_flag, rem_disp, result};

  // Age the view would move to this cycle; bounded by the valid entries, never wraps.
  always_comb begin
    nxt_age = view_age;
    if (prev_btn && !next_btn && state != ST_EMPTY &&
        ({1'b0, view_age} + (AW+1)'(1)) < count)
      nxt_age = view_age + AW'(1);
    else if (next_btn && !prev_btn && state == ST_BROWSE)
      nxt_age = view_age - AW'(1);
  end

  assign raddr = wr_ptr - AW'(1) - nxt_age;

  history_regfile #(.DEPTH(DEPTH), .AW(AW), .W(ENTRY_W)) u_rf (
    .clk   (clk),
    .we    (rst_n && !clear && commit),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wr_ptr      <= '0;
      view_age    <= '0;
      count       <= '0;
      state       <= ST_EMPTY;
      view_result <= '0;
      view_rem    <= '0;
      view_op     <= '0;
      view_div    <= 1'b0;
    end else if (commit) begin
      // New entry goes straight to the display; the memory copy lands on the same edge.
      wr_ptr      <= wr_ptr + AW'(1);
      if (count != (AW+1)'(DEPTH)) count <= count + (AW+1)'(1);
      view_age    <= '0;
      state       <= ST_LIVE;
      view_result <= result;
      view_rem    <= rem_disp;
      view_op     <= alu_op;
      view_div    <= divide_flag;
    end else if (nxt_age != view_age) begin
      view_age    <= nxt_age;
      state       <= (nxt_age == '0) ? ST_LIVE : ST_BROWSE;
      view_result <= rdata[RES_LSB +: RES_W];
      view_rem    <= rdata[REM_LSB +: REM_W];
      view_op     <= rdata[OP_LSB +: OP_W];
      view_div    <= rdata[DIV_BIT];
    end
  end

  assign live  = (state == ST_LIVE);
  assign empty = (count == '0);
endmodule

// File: tb/tb_alu_result_history.sv
// Scoreboard bench for alu_result_history: expected view snapshots queued at drive time, popped after the edge.
module tb_alu_result_history;
  logic        clk = 1'b0;
  logic        rst_n, commit, divide_flag, prev_btn, next_btn, clear;
  logic [15:0] result;
  logic [3:0]  rem_disp;
  logic [1:0]  alu_op;
  logic [15:0] view_result;
  logic [3:0]  view_rem;
  logic [1:0]  view_op;
  logic        view_div, live, empty;
  logic [2:0]  view_age;
  logic [3:0]  count;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] sb[$];
  logic [31:0] got, e;

  always #5 clk = ~clk;

  alu_result_history #(.DEPTH(8), .AW(3)) dut (
    .clk(clk), .rst_n(rst_n), .commit(commit), .result(result), .rem_disp(rem_disp),
    .divide_flag(divide_flag), .alu_op(alu_op), .prev_btn(prev_btn), .next_btn(next_btn),
    .clear(clear), .view_result(view_result), .view_rem(view_rem), .view_op(view_op),
    .view_div(view_div), .view_age(view_age), .count(count), .live(live), .empty(empty)
  );

  function automatic logic [31:0] obs();
    return {view_op, view_div, view_rem, view_result, view_age, count, live, empty};
  endfunction

  function automatic logic [31:0] exp_v(input logic [15:0] r, input logic [3:0] rm, input logic d,
                                        input logic [1:0] op, input logic [2:0] age,
                                        input logic [3:0] cnt, input logic lv);
    return {op, d, rm, r, age, cnt, lv, (cnt == 4'd0)};
  endfunction

  // One clock with the given pulses; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic c, input logic p, input logic n, input logic clr,
                     input logic [15:0] r = '0, input logic [3:0] rm = '0,
                     input logic d = 1'b0, input logic [1:0] op = '0);
    commit = c; prev_btn = p; next_btn = n; clear = clr;
    result = r; rem_disp = rm; divide_flag = d; alu_op = op;
    @(posedge clk); #1;
    commit = 0; prev_btn = 0; next_btn = 0; clear = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    cyc(0, 0, 0, 0);
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    cyc(0, 0, 0, 0);
    sb.push_back(exp_v(0, 0, 0, 0, 0, 0, 0));
    cyc(0, 0, 0, 0);
    rst_n = 1;
    got = obs(); e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL reset got=%h exp=%h", got, e); end
  endtask

  task automatic test_basic();
    sb.push_back(exp_v(16'h0007, 0, 0, 0, 0, 1, 1));
    cyc(1, 0, 0, 0, 16'h0007, 0, 0, 2'b00);
    got = obs(); e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL basic_commit got=%h exp=%h", got, e); end
    sb.push_back(exp_v(16'h0007, 0, 0, 0, 0, 1, 1));
    cyc(0, 1, 0, 0);
    got = obs(); e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL basic_prev_ignored got=%h exp=%h", got, e); end
  endtask

  task automatic test_browse();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      sb.push_back(exp_v(16'(i), 0, 0, 2'(i-1), 0, 4'(i), 1));
      cyc(1, 0, 0, 0, 16'(i), 0, 0, 2'(i-1));
      got = obs(); e = sb.pop_front(); n_cmp++;
      if (got !== e) begin n_bad++; $display("FAIL browse_commit%0d got=%h exp=%h", i, got, e); end
    end
    sb.push_back(exp_v(16'h0002, 0, 0, 2'b01, 1, 3, 0));
    sb.push_back(exp_v(16'h0001, 0, 0, 2'b00, 2, 3, 0));
    sb.push_back(exp_v(16'h0001, 0, 0, 2'b00, 2, 3, 0));
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 0);
      got = obs(); e = sb.pop_front(); n_cmp++;
      if (got !== e) begin n_bad++; $display("FAIL browse_prev%0d got=%h exp=%h", i, got, e); end
    end
    sb.push_back(exp_v(16'h0002, 0, 0, 2'b01, 1, 3, 0));
    sb.push_back(exp_v(16'h0003, 0, 0, 2'b10, 0, 3, 1));
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 1, 0);
      got = obs(); e = sb.pop_front(); n_cmp++;
      if (got !== e) begin n_bad++; $display("FAIL browse_next%0d got=%h exp=%h", i, got, e); end
    end
  endtask

  task automatic test_divide();
    sb.push_back(exp_v(16'h0003, 4'h1, 1, 2'b11, 0, 4, 1));
    cyc(1, 0, 0, 0, 16'h0003, 4'h1, 1'b1, 2'b11);
    got = obs(); e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL divide got=%h exp=%h", got, e); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      sb.push_back(exp_v(16'h0010 + 16'(i), 4'(i), 1'(i), 2'(i), 0, (i < 8) ? 4'(i+1) : 4'd8, 1));
      cyc(1, 0, 0, 0, 16'h0010 + 16'(i), 4'(i), 1'(i), 2'(i));
      got = obs(); e = sb.pop_front(); n_cmp++;
      if (got !== e) begin n_bad++; $display("FAIL wrap_commit%0d got=%h exp=%h", i, got, e); end
    end
    for (int k = 1; k <= 8; k++) begin
      int a;
      a = (k > 7) ? 7 : k;
      sb.push_back(exp_v(16'h0019 - 16'(a), 4'(9-a), 1'(9-a), 2'(9-a), 3'(a), 8, 0));
      cyc(0, 1, 0, 0);
      got = obs(); e = sb.pop_front(); n_cmp++;
      if (got !== e) begin n_bad++; $display("FAIL wrap_prev%0d got=%h exp=%h", k, got, e); end
    end
  endtask

  task automatic test_priority();
    for (int k = 6; k >= 3; k--) begin
      sb.push_back(exp_v(16'h0019 - 16'(k), 4'(9-k), 1'(9-k), 2'(9-k), 3'(k), 8, 0));
      cyc(0, 0, 1, 0);
      got = obs(); e = sb.pop_front(); n_cmp++;
      if (got !== e) begin n_bad++; $display("FAIL prio_next_age%0d got=%h exp=%h", k, got, e); end
    end
    sb.push_back(exp_v(16'h00AA, 0, 0, 0, 0, 8, 1));
    cyc(1, 1, 0, 0, 16'h00AA, 0, 0, 0);
    got = obs(); e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL prio_commit_wins got=%h exp=%h", got, e); end
    sb.push_back(exp_v(16'h0019, 4'h9, 1, 2'b01, 1, 8, 0));
    cyc(0, 1, 0, 0);
    got = obs(); e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL prio_prev_after got=%h exp=%h", got, e); end
    sb.push_back(exp_v(16'h0019, 4'h9, 1, 2'b01, 1, 8, 0));
    cyc(0, 1, 1, 0);
    got = obs(); e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL prio_prev_next got=%h exp=%h", got, e); end
  endtask

  task automatic test_clear();
    rst_n = 0;
    sb.push_back(exp_v(0, 0, 0, 0, 0, 0, 0));
    cyc(0, 0, 0, 0);
    rst_n = 1;
    got = obs(); e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL midbrowse_reset got=%h exp=%h", got, e); end
    sb.push_back(exp_v(16'h0055, 0, 0, 0, 0, 1, 1));
    cyc(1, 0, 0, 0, 16'h0055, 0, 0, 0);
    got = obs(); e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL after_reset_commit got=%h exp=%h", got, e); end
    cyc(1, 0, 0, 0, 16'h0056, 0, 0, 1);
    sb.push_back(exp_v(16'h0055, 0, 0, 0, 1, 2, 0));
    cyc(0, 1, 0, 0);
    got = obs(); e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL pre_clear_browse got=%h exp=%h", got, e); end
    sb.push_back(exp_v(0, 0, 0, 0, 0, 0, 0));
    cyc(0, 0, 0, 1);
    got = obs(); e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL clear got=%h exp=%h", got, e); end
    sb.push_back(exp_v(16'h0055, 4'h2, 1, 2'b10, 0, 1, 1));
    cyc(1, 0, 0, 0, 16'h0055, 4'h2, 1, 2'b10);
    got = obs(); e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL after_clear_commit got=%h exp=%h", got, e); end
    sb.push_back(exp_v(0, 0, 0, 0, 0, 0, 0));
    cyc(1, 0, 0, 1, 16'h0077, 0, 0, 0);
    got = obs(); e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL clear_beats_commit got=%h exp=%h", got, e); end
    sb.push_back(exp_v(0, 0, 0, 0, 0, 0, 0));
    cyc(0, 1, 0, 0);
    got = obs(); e = sb.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL empty_prev_ignored got=%h exp=%h", got, e); end
  endtask

  initial begin
    rst_n = 1; commit = 0; prev_btn = 0; next_btn = 0; clear = 0;
    result = 0; rem_disp = 0; divide_flag = 0; alu_op = 0;
    #2;
    test_reset();
    test_basic();
    test_browse();
    test_divide();
    test_wrap();
    test_priority();
    test_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
